// File: rtl/hcordic_pkg.sv
// hcordic_pkg: shared encodings and field positions
// for the HCORDIC datapath stages.
package hcordic_pkg;

   typedef enum logic [1:0] {
      mode_circular   = 2'b00,
      mode_linear     = 2'b01,
      mode_hyperbolic = 2'b10
   } mode_t;

   typedef enum logic [1:0] {
      no_idle     = 2'b00,
      allign_idle = 2'b01,
      put_idle    = 2'b10
   } idle_t;

   localparam int SIGN    = 35;
   localparam int EXP_HI  = 34;
   localparam int EXP_LO  = 27;
   localparam int MANT_HI = 26;
   localparam int MANT_LO = 0;
   localparam int SIG_LO  = 3;
   localparam int SIG_W   = MANT_HI - SIG_LO + 1;
   localparam int PROD_W  = 50;

endpackage

// File: rtl/multiply_stage_if.sv
// multiply_stage_if: operand/product bus between the
// multiply stage and its split 24x24 multiplier.
interface multiply_stage_if;
   import hcordic_pkg::*;

   logic [SIG_W-1:0]   a;
   logic [SIG_W-1:0]   b;
   logic               kill;
   logic [2*SIG_W-1:0] p;

   modport master (output a, b, kill, input p);
   modport slave  (input a, b, kill, output p);

endinterface

// File: rtl/mult24_split2.sv
// mult24_split2: 24x24 multiply, 12x12 partial products in
// the first stage, summed in the second. Latency 2.
module mult24_split2
   import hcordic_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   multiply_stage_if.slave  bus
);

   logic [23:0] hh_q, hl_q, lh_q, ll_q;
   logic [47:0] p_q, p_d;
   logic [24:0] mid;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hh_q <= '0;
         hl_q <= '0;
         lh_q <= '0;
         ll_q <= '0;
      end else begin
         hh_q <= {12'd0, bus.a[23:12]} * {12'd0, bus.b[23:12]};
         hl_q <= {12'd0, bus.a[23:12]} * {12'd0, bus.b[11:0]};
         lh_q <= {12'd0, bus.a[11:0]} * {12'd0, bus.b[23:12]};
         ll_q <= {12'd0, bus.a[11:0]} * {12'd0, bus.b[11:0]};
      end
   end

   assign mid = {1'b0, hl_q} + {1'b0, lh_q};

   always_comb begin
      p_d = {hh_q, 24'd0}
          + {11'd0, mid, 12'd0}
          + {24'd0, ll_q};
   end

   // kill arrives aligned with the partial products
   always_ff @(posedge clk_i) begin
      if (rst_i) p_q <= '0;
      else       p_q <= bus.kill ? '0 : p_d;
   end

   assign bus.p = p_q;

endmodule

// File: rtl/multiply_stage.sv
// multiply_stage: two-stage mantissa multiply with sign/exponent merge.
// Define MULTIPLY_EXP_SAT_EN to saturate the exponent instead of wrapping.
module multiply_stage
   import hcordic_pkg::*;
#(
   parameter int LAT = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [35:0]       cout_Special,
   input  logic [35:0]       zout_Special,
   input  logic [31:0]       sout_Special,
   input  logic [1:0]        modeout_Special,
   input  logic              operationout_Special,
   input  logic              NatLogFlagout_Special,
   input  logic [7:0]        InsTag_Special,
   input  logic [1:0]        idle_Special,
   output logic [35:0]       cout_Multiply,
   output logic [35:0]       zout_Multiply,
   output logic [31:0]       sout_Multiply,
   output logic [PROD_W-1:0] productout_Multiply,
   output logic [1:0]        modeout_Multiply,
   output logic              operationout_Multiply,
   output logic              NatLogFlagout_Multiply,
   output logic [7:0]        InsTag_Multiply,
   output logic [1:0]        idle_Multiply
);

   if (LAT != 2) begin : g_lat_unsupported
   end

   logic [35:0] c_q, z_q, cout_q, zout_q, zout_d;
   logic [31:0] s_q, sout_q;
   logic [1:0]  mode_q, mode2_q, idle_q, idle2_q;
   logic        op_q, op2_q, nl_q, nl2_q;
   logic [7:0]  tag_q, tag2_q;
   logic [9:0]  esum;
   logic [7:0]  exp_r;

   multiply_stage_if mbus ();

   assign mbus.a    = zout_Special[MANT_HI:SIG_LO];
   assign mbus.b    = cout_Special[MANT_HI:SIG_LO];
   assign mbus.kill = (idle_q != no_idle);

   mult24_split2 u_mult (
      .clk_i (clock),
      .rst_i (reset),
      .bus   (mbus.slave)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         c_q    <= '0;
         z_q    <= '0;
         s_q    <= '0;
         mode_q <= '0;
         op_q   <= 1'b0;
         nl_q   <= 1'b0;
         tag_q  <= '0;
         idle_q <= put_idle;
      end else begin
         c_q    <= cout_Special;
         z_q    <= zout_Special;
         s_q    <= sout_Special;
         mode_q <= modeout_Special;
         op_q   <= operationout_Special;
         nl_q   <= NatLogFlagout_Special;
         tag_q  <= InsTag_Special;
         idle_q <= idle_Special;
      end
   end

   // +1 pairs with the downstream keep-or-decrement rule
   assign esum = {{2{z_q[EXP_HI]}}, z_q[EXP_HI:EXP_LO]}
               + {{2{c_q[EXP_HI]}}, c_q[EXP_HI:EXP_LO]}
               + 10'd1;

`ifdef MULTIPLY_EXP_SAT_EN
   always_comb begin
      exp_r = esum[7:0];
      if ($signed(esum) > 10'sd127)
         exp_r = 8'h7F;
      else if ($signed(esum) < -10'sd128)
         exp_r = 8'h80;
   end
`else
   logic unused_esum;
   assign unused_esum = ^esum[9:8];
   always_comb begin
      exp_r = esum[7:0];
   end
`endif

   always_comb begin
      zout_d = z_q;
      if (idle_q == no_idle) begin
         zout_d[SIGN]          = z_q[SIGN] ^ c_q[SIGN];
         zout_d[EXP_HI:EXP_LO] = exp_r;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cout_q  <= '0;
         zout_q  <= '0;
         sout_q  <= '0;
         mode2_q <= '0;
         op2_q   <= 1'b0;
         nl2_q   <= 1'b0;
         tag2_q  <= '0;
         idle2_q <= put_idle;
      end else begin
         cout_q  <= c_q;
         zout_q  <= zout_d;
         sout_q  <= s_q;
         mode2_q <= mode_q;
         op2_q   <= op_q;
         nl2_q   <= nl_q;
         tag2_q  <= tag_q;
         idle2_q <= idle_q;
      end
   end

   assign cout_Multiply          = cout_q;
   assign zout_Multiply          = zout_q;
   assign sout_Multiply          = sout_q;
   assign productout_Multiply    = {mbus.p, {(PROD_W-2*SIG_W){1'b0}}};
   assign modeout_Multiply       = mode2_q;
   assign operationout_Multiply  = op2_q;
   assign NatLogFlagout_Multiply = nl2_q;
   assign InsTag_Multiply        = tag2_q;
   assign idle_Multiply          = idle2_q;

endmodule
